// File: rtl/resize_job_sched_if.sv
// -----------------------------------------------------------------------------
// resize_job_sched_if
// Host-side handshake bundle for the resize job scheduler.
//   job channel  : job_valid / job_ready / job_id / job_desc (256b descriptor)
//   done channel : done_valid / done_ready / done_id / done_exit / done_timeout
// master = host requester (drives jobs, accepts completions)
// slave  = scheduler      (accepts jobs, drives completions)
// -----------------------------------------------------------------------------
interface resize_job_sched_if #(
    parameter int unsigned IdWidth = 4
);
    logic               job_valid;
    logic               job_ready;
    logic [IdWidth-1:0] job_id;
    logic [255:0]       job_desc;

    logic               done_valid;
    logic               done_ready;
    logic [IdWidth-1:0] done_id;
    logic [31:0]        done_exit;
    logic               done_timeout;

    modport master (
        output job_valid, job_id, job_desc, done_ready,
        input  job_ready, done_valid, done_id, done_exit, done_timeout
    );

    modport slave (
        input  job_valid, job_id, job_desc, done_ready,
        output job_ready, done_valid, done_id, done_exit, done_timeout
    );
endinterface

// File: rtl/resize_job_sched.sv
// -----------------------------------------------------------------------------
// resize_job_sched
// Queues resize job descriptors, launches them one at a time onto the ctrlreg
// config/start inputs, follows the accelerator idle/exit handshake and emits
// one completion record per job.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   bus (slave modport)    job push channel and completion channel
//   src_width_o ..
//   dst_image_size_o       8 x 32b config fields of the active job
//   start_o                one-cycle launch pulse to ctrlreg
//   idle_i                 accelerator idle flag from ctrlreg
//   exit_i                 exit code from ctrlreg (nonzero for one cycle)
//   busy_o                 scheduler not in IDLE
//   queue_count_o          job FIFO occupancy
// -----------------------------------------------------------------------------
module resize_job_sched #(
    parameter int unsigned Depth       = 4,
    parameter int unsigned IdWidth     = 4,
    parameter int unsigned TimeoutCycs = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    resize_job_sched_if.slave          bus,
    output logic [31:0]                src_width_o,
    output logic [31:0]                src_height_o,
    output logic [31:0]                src_offset_o,
    output logic [31:0]                src_image_size_o,
    output logic [31:0]                dst_width_o,
    output logic [31:0]                dst_height_o,
    output logic [31:0]                dst_offset_o,
    output logic [31:0]                dst_image_size_o,
    output logic                       start_o,
    input  logic                       idle_i,
    input  logic [31:0]                exit_i,
    output logic                       busy_o,
    output logic [$clog2(Depth+1)-1:0] queue_count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned EntW = IdWidth + 256;

    // Counter value at which the job is forced to complete.
    localparam bit          TimeoutEn   = (TimeoutCycs != 0);
    localparam logic [31:0] TimeoutLast = (TimeoutCycs == 0) ? 32'd0 : 32'(TimeoutCycs - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_ACK,
        S_RUN,
        S_REPORT
    } state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // ---------------------------------------------------------------- FIFO
    logic [EntW-1:0] mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            full;
    logic            push;
    logic            pop;

    assign full  = (count_q == CntW'(Depth));
    assign push  = bus.job_valid && !full;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is pure data; occupancy tracking makes stale entries unreachable.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.job_id, bus.job_desc};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
        end
    end

    // ---------------------------------------------------------------- FSM
    state_e             state_q, state_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [31:0]        exit_q, exit_d;
    logic               timeout_q, timeout_d;
    logic [IdWidth-1:0] id_q;
    logic [255:0]       cfg_q;
    logic               expired;

    assign expired = TimeoutEn && (cnt_q == TimeoutLast);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        exit_d    = exit_q;
        timeout_d = timeout_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A previous timed-out job may still be running; hold the
                // queue until the accelerator reports idle again.
                if ((count_q != '0) && idle_i) begin
                    pop     = 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                cnt_d = sat_inc(cnt_q);
                if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_REPORT;
                end else if (!idle_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = sat_inc(cnt_q);
                if (exit_i != 32'd0) begin
                    exit_d = exit_i;
                end
                // Completion seen in the expiry cycle takes priority.
                if (idle_i) begin
                    timeout_d = 1'b0;
                    state_d   = S_REPORT;
                end else if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_REPORT;
                end
            end
            S_REPORT: begin
                if (bus.done_ready) begin
                    exit_d    = '0;
                    timeout_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            exit_q    <= '0;
            timeout_q <= 1'b0;
            id_q      <= '0;
            cfg_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            exit_q    <= exit_d;
            timeout_q <= timeout_d;
            if (pop) begin
                {id_q, cfg_q} <= mem_q[rd_ptr_q];
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    assign bus.job_ready    = !full;
    assign bus.done_valid   = (state_q == S_REPORT);
    assign bus.done_id      = id_q;
    assign bus.done_exit    = exit_q;
    assign bus.done_timeout = timeout_q;

    assign start_o       = (state_q == S_LAUNCH);
    assign busy_o        = (state_q != S_IDLE);
    assign queue_count_o = count_q;

    assign src_width_o      = cfg_q[31:0];
    assign src_height_o     = cfg_q[63:32];
    assign src_offset_o     = cfg_q[95:64];
    assign src_image_size_o = cfg_q[127:96];
    assign dst_width_o      = cfg_q[159:128];
    assign dst_height_o     = cfg_q[191:160];
    assign dst_offset_o     = cfg_q[223:192];
    assign dst_image_size_o = cfg_q[255:224];

endmodule

// File: tb/tb_resize_job_sched.sv
// -----------------------------------------------------------------------------
// tb_resize_job_sched
// Directed bench for resize_job_sched (Depth=4, IdWidth=4, TimeoutCycs=10).
// Inputs change 1ns after the rising edge; outputs are read there too.
// -----------------------------------------------------------------------------
module tb_resize_job_sched;
    localparam int unsigned Depth       = 4;
    localparam int unsigned IdWidth     = 4;
    localparam int unsigned TimeoutCycs = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        idle;
    logic [31:0] exit_v;
    logic        start;
    logic        busy;
    logic [2:0]  qcount;
    logic [31:0] src_w, src_h, src_off, src_size, dst_w, dst_h, dst_off, dst_size;
    logic        start_prev = 1'b0;

    int checks = 0;
    int errors = 0;

    resize_job_sched_if #(.IdWidth(IdWidth)) bus ();

    resize_job_sched #(
        .Depth(Depth), .IdWidth(IdWidth), .TimeoutCycs(TimeoutCycs)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus.slave),
        .src_width_o(src_w), .src_height_o(src_h), .src_offset_o(src_off),
        .src_image_size_o(src_size), .dst_width_o(dst_w), .dst_height_o(dst_h),
        .dst_offset_o(dst_off), .dst_image_size_o(dst_size),
        .start_o(start), .idle_i(idle), .exit_i(exit_v),
        .busy_o(busy), .queue_count_o(qcount)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // start must never be high on two consecutive cycles
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            assert (!(start && start_prev)) else begin
                errors++;
                $error("FAIL start_double: observed start high two cycles in a row, expected a low cycle between");
            end
        end
        start_prev = start;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Field k of the descriptor is base+k, src_w at [31:0].
    function automatic logic [255:0] mk_desc(input logic [31:0] b);
        return {b + 32'd7, b + 32'd6, b + 32'd5, b + 32'd4,
                b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    task automatic chk_cfg(input logic [31:0] b);
        chk("cfg_src_w",    src_w,    b);
        chk("cfg_src_h",    src_h,    b + 32'd1);
        chk("cfg_src_off",  src_off,  b + 32'd2);
        chk("cfg_src_size", src_size, b + 32'd3);
        chk("cfg_dst_w",    dst_w,    b + 32'd4);
        chk("cfg_dst_h",    dst_h,    b + 32'd5);
        chk("cfg_dst_off",  dst_off,  b + 32'd6);
        chk("cfg_dst_size", dst_size, b + 32'd7);
    endtask

    task automatic push(input logic [3:0] id, input logic [31:0] b);
        bus.job_valid = 1'b1;
        bus.job_id    = id;
        bus.job_desc  = mk_desc(b);
        tick();
        bus.job_valid = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        while (start !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        chk("start_seen", {31'd0, start}, 32'd1);
    endtask

    // Called in the cycle after LAUNCH; drives the accelerator through one job.
    task automatic finish_job(input logic [3:0] id, input logic [31:0] b,
                              input logic [31:0] exitc, input bit same, input bit ack);
        chk("start_pulse_low", {31'd0, start}, 32'd0);
        idle = 1'b0;
        tick();
        if (same) begin
            exit_v = exitc;
            idle   = 1'b1;
            tick();
            exit_v = 32'd0;
        end else begin
            exit_v = exitc;
            tick();
            exit_v = 32'd0;
            idle   = 1'b1;
            tick();
        end
        chk("done_valid", {31'd0, bus.done_valid}, 32'd1);
        chk("done_id", {28'd0, bus.done_id}, {28'd0, id});
        chk("done_exit", bus.done_exit, exitc);
        chk("done_timeout", {31'd0, bus.done_timeout}, 32'd0);
        chk_cfg(b);
        if (ack) begin
            bus.done_ready = 1'b1;
            tick();
            bus.done_ready = 1'b0;
            chk("done_cleared", {31'd0, bus.done_valid}, 32'd0);
            chk("busy_after_done", {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic run_job(input logic [3:0] id, input logic [31:0] b,
                           input logic [31:0] exitc, input bit same, input bit ack);
        wait_start();
        chk_cfg(b);
        tick();
        finish_job(id, b, exitc, same, ack);
    endtask

    initial begin
        idle           = 1'b1;
        exit_v         = 32'd0;
        bus.job_valid  = 1'b0;
        bus.job_id     = '0;
        bus.job_desc   = '0;
        bus.done_ready = 1'b0;

        // reset state
        #12;
        chk("rst_ready", {31'd0, bus.job_ready}, 32'd1);
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_done_valid", {31'd0, bus.done_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_count", {29'd0, qcount}, 32'd0);
        chk("rst_src_w", src_w, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // single job, exact latency
        push(4'd3, 32'd640);
        chk("t1_start_c1", {31'd0, start}, 32'd0);
        chk("t1_count_c1", {29'd0, qcount}, 32'd1);
        tick();
        chk("t1_start_c2", {31'd0, start}, 32'd1);
        chk("t1_busy_c2", {31'd0, busy}, 32'd1);
        chk("t1_count_c2", {29'd0, qcount}, 32'd0);
        chk_cfg(32'd640);
        tick();
        finish_job(4'd3, 32'd640, 32'h5, 1'b0, 1'b1);

        // FIFO fill and back-pressure, in-order completion
        idle = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.job_valid = 1'b1;
            bus.job_id    = 4'(i);
            bus.job_desc  = mk_desc(32'd100 + 32'(i));
            chk("t2_ready_fill", {31'd0, bus.job_ready}, 32'd1);
            tick();
        end
        bus.job_id   = 4'd4;
        bus.job_desc = mk_desc(32'd104);
        chk("t2_full_ready", {31'd0, bus.job_ready}, 32'd0);
        chk("t2_full_count", {29'd0, qcount}, 32'd4);
        tick();
        chk("t2_stall_count", {29'd0, qcount}, 32'd4);
        chk("t2_stall_ready", {31'd0, bus.job_ready}, 32'd0);
        chk("t2_no_launch_busy", {31'd0, start}, 32'd0);
        idle = 1'b1;
        tick();
        chk("t2_pop_start", {31'd0, start}, 32'd1);
        chk("t2_pop_count", {29'd0, qcount}, 32'd3);
        chk("t2_pop_ready", {31'd0, bus.job_ready}, 32'd1);
        chk_cfg(32'd100);
        tick();
        bus.job_valid = 1'b0;
        chk("t2_fifth_in", {29'd0, qcount}, 32'd4);
        finish_job(4'd0, 32'd100, 32'h10, 1'b0, 1'b1);
        for (int i = 1; i < 5; i++) begin
            run_job(4'(i), 32'd100 + 32'(i), 32'h10 + 32'(i), 1'b0, 1'b1);
        end

        // timeout, then launch held until idle returns
        push(4'd9, 32'd900);
        wait_start();
        tick();
        idle = 1'b0;
        push(4'd10, 32'd1000);
        repeat (8) tick();
        chk("t3_not_yet", {31'd0, bus.done_valid}, 32'd0);
        chk("t3_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("t3_done_valid", {31'd0, bus.done_valid}, 32'd1);
        chk("t3_timeout", {31'd0, bus.done_timeout}, 32'd1);
        chk("t3_id", {28'd0, bus.done_id}, 32'd9);
        chk("t3_exit", bus.done_exit, 32'd0);
        bus.done_ready = 1'b1;
        tick();
        bus.done_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_start", {31'd0, start}, 32'd0);
            chk("t3_hold_count", {29'd0, qcount}, 32'd1);
            tick();
        end
        idle = 1'b1;
        tick();
        chk("t3_relaunch", {31'd0, start}, 32'd1);
        chk_cfg(32'd1000);
        tick();
        finish_job(4'd10, 32'd1000, 32'd0, 1'b0, 1'b1);

        // exit and idle in the same cycle; then no exit at all
        push(4'd7, 32'd700);
        run_job(4'd7, 32'd700, 32'hDEAD, 1'b1, 1'b1);
        push(4'd8, 32'd800);
        run_job(4'd8, 32'd800, 32'd0, 1'b0, 1'b1);

        // completion held by done_ready low
        push(4'd11, 32'd1100);
        push(4'd12, 32'd1200);
        run_job(4'd11, 32'd1100, 32'h11, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t5_valid", {31'd0, bus.done_valid}, 32'd1);
            chk("t5_id", {28'd0, bus.done_id}, 32'd11);
            chk("t5_exit", bus.done_exit, 32'h11);
            chk("t5_no_start", {31'd0, start}, 32'd0);
        end
        chk_cfg(32'd1100);
        bus.done_ready = 1'b1;
        tick();
        bus.done_ready = 1'b0;
        chk("t5_idle_cycle", {31'd0, start}, 32'd0);
        tick();
        chk("t5_launch", {31'd0, start}, 32'd1);
        chk_cfg(32'd1200);
        tick();
        finish_job(4'd12, 32'd1200, 32'h12, 1'b0, 1'b1);

        // reset while running with two queued
        push(4'd1, 32'd10);
        push(4'd2, 32'd20);
        push(4'd3, 32'd30);
        idle = 1'b0;
        tick();
        chk("t6_busy", {31'd0, busy}, 32'd1);
        chk("t6_count", {29'd0, qcount}, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("t6_start", {31'd0, start}, 32'd0);
        chk("t6_count_rst", {29'd0, qcount}, 32'd0);
        chk("t6_done_valid", {31'd0, bus.done_valid}, 32'd0);
        chk("t6_ready", {31'd0, bus.job_ready}, 32'd1);
        chk("t6_busy_rst", {31'd0, busy}, 32'd0);
        chk("t6_src_w", src_w, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
